change_dispenser: RTL and testbench

Change-payout block for the vending machine. It accepts a change amount from the sale controller over a valid/ready handshake and plans a greedy payout from a three-denomination coin hopper (50/20/10). It drives one coin-eject strobe per coin, tracks the hopper inventory, and signals completion or an unpayable amount. It sits between the sale controller and the coin hopper solenoids.

---
 rtl/vend_pkg.sv | 18 +
 rtl/change_dispenser_if.sv | 30 +++
 rtl/change_planner.sv | 41 ++++
 rtl/change_dispenser.sv | 161 ++++++++++++++++
 tb/tb_change_dispenser.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin values, default amount width and
// the change-dispenser state encoding.
package vend_pkg;

    localparam int unsigned COIN_FIFTY    = 50;
    localparam int unsigned COIN_TWENTY   = 20;
    localparam int unsigned COIN_TEN      = 10;
    localparam int unsigned AMT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PAY,
        GAP,
        DONE
    } disp_state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Sale-controller / hopper-side bundle of the change dispenser.
interface change_dispenser_if #(
    parameter int unsigned AMT_W = vend_pkg::AMT_W_DEFAULT,
    parameter int unsigned CNT_W = 6
);
    logic             i_req_valid;
    logic [AMT_W-1:0] i_req_amount;
    logic             o_req_ready;
    logic             i_refill;
    logic             o_fifty_coin;
    logic             o_twenty_coin;
    logic             o_ten_coin;
    logic             o_done;
    logic             o_error;
    logic [CNT_W-1:0] o_fifty_cnt;
    logic [CNT_W-1:0] o_twenty_cnt;
    logic [CNT_W-1:0] o_ten_cnt;

    modport master (
        output i_req_valid, i_req_amount, i_refill,
        input  o_req_ready, o_fifty_coin, o_twenty_coin, o_ten_coin,
        input  o_done, o_error, o_fifty_cnt, o_twenty_cnt, o_ten_cnt
    );

    modport slave (
        input  i_req_valid, i_req_amount, i_refill,
        output o_req_ready, o_fifty_coin, o_twenty_coin, o_ten_coin,
        output o_done, o_error, o_fifty_cnt, o_twenty_cnt, o_ten_cnt
    );
endinterface

// File: rtl/change_planner.sv
// Combinational greedy payout plan (50, then 20, then 10) limited by the
// available coin counts; payable is low when a remainder is left over.
module change_planner
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W = AMT_W_DEFAULT,
    parameter int unsigned CNT_W = 6
) (
    input  logic [AMT_W-1:0] amount,
    input  logic [CNT_W-1:0] c50,
    input  logic [CNT_W-1:0] c20,
    input  logic [CNT_W-1:0] c10,
    output logic [CNT_W-1:0] n50,
    output logic [CNT_W-1:0] n20,
    output logic [CNT_W-1:0] n10,
    output logic             payable
);
    localparam int unsigned WW = (AMT_W > CNT_W) ? AMT_W : CNT_W;

    logic [WW-1:0] q50, q20, q10;
    logic [WW-1:0] m50, m20, m10;
    logic [WW-1:0] r0, r1, r2, r3;

    always_comb begin
        r0  = WW'(amount);
        q50 = r0 / WW'(COIN_FIFTY);
        m50 = (q50 < WW'(c50)) ? q50 : WW'(c50);
        r1  = r0 - m50 * WW'(COIN_FIFTY);
        q20 = r1 / WW'(COIN_TWENTY);
        m20 = (q20 < WW'(c20)) ? q20 : WW'(c20);
        r2  = r1 - m20 * WW'(COIN_TWENTY);
        q10 = r2 / WW'(COIN_TEN);
        m10 = (q10 < WW'(c10)) ? q10 : WW'(c10);
        r3  = r2 - m10 * WW'(COIN_TEN);
        n50     = CNT_W'(m50);
        n20     = CNT_W'(m20);
        n10     = CNT_W'(m10);
        payable = (r3 == '0);
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout FSM: accepts an amount, plans a greedy payout, strobes one
// coin per PAY cycle with GAP_CYCLES idle cycles between coins, tracks stock.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W       = AMT_W_DEFAULT,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned INIT_FIFTY  = 10,
    parameter int unsigned INIT_TWENTY = 10,
    parameter int unsigned INIT_TEN    = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    change_dispenser_if.slave   bus
);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    disp_state_e      state_q, state_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [CNT_W-1:0] n50_q, n50_d, n20_q, n20_d, n10_q, n10_d;
    logic [CNT_W-1:0] c50_q, c50_d, c20_q, c20_d, c10_q, c10_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             fifty_q, fifty_d, twenty_q, twenty_d, ten_q, ten_d;
    logic             done_q, done_d, error_q, error_d;

    logic [CNT_W-1:0] p50, p20, p10;
    logic             payable;

    change_planner #(
        .AMT_W (AMT_W),
        .CNT_W (CNT_W)
    ) u_planner (
        .amount  (amt_q),
        .c50     (c50_q),
        .c20     (c20_q),
        .c10     (c10_q),
        .n50     (p50),
        .n20     (p20),
        .n10     (p10),
        .payable (payable)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            amt_q    <= '0;
            n50_q    <= '0;
            n20_q    <= '0;
            n10_q    <= '0;
            c50_q    <= CNT_W'(INIT_FIFTY);
            c20_q    <= CNT_W'(INIT_TWENTY);
            c10_q    <= CNT_W'(INIT_TEN);
            gap_q    <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            fifty_q  <= 1'b0;
            twenty_q <= 1'b0;
            ten_q    <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            amt_q    <= amt_d;
            n50_q    <= n50_d;
            n20_q    <= n20_d;
            n10_q    <= n10_d;
            c50_q    <= c50_d;
            c20_q    <= c20_d;
            c10_q    <= c10_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            fifty_q  <= fifty_d;
            twenty_q <= twenty_d;
            ten_q    <= ten_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Next state; outputs are derived from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        amt_d   = amt_q;
        n50_d   = n50_q;
        n20_d   = n20_q;
        n10_d   = n10_q;
        c50_d   = c50_q;
        c20_d   = c20_q;
        c10_d   = c10_q;
        gap_d   = gap_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.i_refill) begin
                    c50_d = CNT_W'(INIT_FIFTY);
                    c20_d = CNT_W'(INIT_TWENTY);
                    c10_d = CNT_W'(INIT_TEN);
                end
                if (bus.i_req_valid) begin
                    amt_d   = bus.i_req_amount;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!payable) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    n50_d   = p50;
                    n20_d   = p20;
                    n10_d   = p10;
                    state_d = ((p50 | p20 | p10) != '0) ? PAY : DONE;
                end
            end
            PAY: begin
                if (n50_q != '0) begin
                    n50_d = n50_q - CNT_W'(1);
                    c50_d = c50_q - CNT_W'(1);
                end else if (n20_q != '0) begin
                    n20_d = n20_q - CNT_W'(1);
                    c20_d = c20_q - CNT_W'(1);
                end else if (n10_q != '0) begin
                    n10_d = n10_q - CNT_W'(1);
                    c10_d = c10_q - CNT_W'(1);
                end
                gap_d   = '0;
                state_d = ((n50_d | n20_d | n10_d) != '0) ? GAP : DONE;
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = PAY;
                else                                 gap_d   = gap_q + GAP_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d  = (state_d == IDLE);
        fifty_d  = (state_d == PAY) && (n50_d != '0);
        twenty_d = (state_d == PAY) && (n50_d == '0) && (n20_d != '0);
        ten_d    = (state_d == PAY) && (n50_d == '0) && (n20_d == '0) && (n10_d != '0);
        done_d   = (state_d == DONE);
        error_d  = (state_d == DONE) && err_d;
    end

    assign bus.o_req_ready   = ready_q;
    assign bus.o_fifty_coin  = fifty_q;
    assign bus.o_twenty_coin = twenty_q;
    assign bus.o_ten_coin    = ten_q;
    assign bus.o_done        = done_q;
    assign bus.o_error       = error_q;
    assign bus.o_fifty_cnt   = c50_q;
    assign bus.o_twenty_cnt  = c20_q;
    assign bus.o_ten_cnt     = c10_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: four instances with different hopper
// initial stocks, cycle-exact checks of strobes, done/error, ready and counts.
module tb_change_dispenser;

    localparam int unsigned NDUT = 4;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    logic       req_valid  [NDUT];
    logic [7:0] req_amount [NDUT];
    logic       refill     [NDUT];
    logic       fifty [NDUT], twenty [NDUT], ten [NDUT];
    logic       done  [NDUT], err    [NDUT], ready [NDUT];
    logic [5:0] c50   [NDUT], c20    [NDUT], c10   [NDUT];

    // Instance 0: 10/10/10, 1: 0/3/0, 2: 1/3/0, 3: 10/10/1
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        change_dispenser_if #(.AMT_W(8), .CNT_W(6)) bus ();
        change_dispenser #(
            .AMT_W       (8),
            .CNT_W       (6),
            .GAP_CYCLES  (1),
            .INIT_FIFTY  ((g == 1) ? 0 : (g == 2) ? 1 : 10),
            .INIT_TWENTY ((g == 1 || g == 2) ? 3 : 10),
            .INIT_TEN    ((g == 1 || g == 2) ? 0 : (g == 3) ? 1 : 10)
        ) dut (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .bus     (bus.slave)
        );
        assign bus.i_req_valid  = req_valid[g];
        assign bus.i_req_amount = req_amount[g];
        assign bus.i_refill     = refill[g];
        assign fifty[g]  = bus.o_fifty_coin;
        assign twenty[g] = bus.o_twenty_coin;
        assign ten[g]    = bus.o_ten_coin;
        assign done[g]   = bus.o_done;
        assign err[g]    = bus.o_error;
        assign ready[g]  = bus.o_req_ready;
        assign c50[g]    = bus.o_fifty_cnt;
        assign c20[g]    = bus.o_twenty_cnt;
        assign c10[g]    = bus.o_ten_cnt;
    end

    int checks = 0;
    int errors = 0;

    // Per-request observations, cycle numbers relative to the accept edge
    int   r_first [3];
    int   r_num   [3];
    int   r_done_cyc, r_ready_cyc, r_multi;
    logic r_err;

    task automatic run_req(input int d, input int amt, input logic refill_idle,
                           input logic refill_busy);
        @(negedge i_clk);
        req_valid[d]  = 1'b1;
        req_amount[d] = 8'(amt);
        refill[d]     = refill_idle;
        @(posedge i_clk);
        #1;
        req_valid[d] = 1'b0;
        refill[d]    = refill_busy;
        for (int k = 0; k < 3; k++) begin
            r_first[k] = -1;
            r_num[k]   = 0;
        end
        r_done_cyc  = -1;
        r_ready_cyc = -1;
        r_multi     = 0;
        r_err       = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (fifty[d])  begin r_num[0]++; if (r_first[0] < 0) r_first[0] = cyc; end
            if (twenty[d]) begin r_num[1]++; if (r_first[1] < 0) r_first[1] = cyc; end
            if (ten[d])    begin r_num[2]++; if (r_first[2] < 0) r_first[2] = cyc; end
            if (int'(fifty[d]) + int'(twenty[d]) + int'(ten[d]) > 1) r_multi++;
            if (done[d] && r_done_cyc < 0) begin
                r_done_cyc = cyc;
                r_err      = err[d];
                refill[d]  = 1'b0;
            end
            if (ready[d] && r_done_cyc >= 0) begin
                r_ready_cyc = cyc;
                break;
            end
            @(posedge i_clk);
            #1;
        end
        refill[d] = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready[0]); end
        checks++; if ({fifty[0], twenty[0], ten[0]} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {fifty[0], twenty[0], ten[0]}); end
        checks++; if ({done[0], err[0]} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b expected 00", {done[0], err[0]}); end
        checks++; if ({c50[0], c20[0], c10[0]} !== {6'd10, 6'd10, 6'd10}) begin errors++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 10/10/10", c50[0], c20[0], c10[0]); end
        checks++; if ({c50[3], c20[3], c10[3]} !== {6'd10, 6'd10, 6'd1}) begin errors++; $display("FAIL reset_counts_d3: got %0d/%0d/%0d expected 10/10/1", c50[3], c20[3], c10[3]); end
    endtask

    task automatic test_unpayable();
        run_req(0, 25, 1'b0, 1'b0);
        checks++; if (r_done_cyc !== 2) begin errors++; $display("FAIL err25_done_cycle: got %0d expected 2", r_done_cyc); end
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL err25_error: got %b expected 1", r_err); end
        checks++; if (r_num[0] + r_num[1] + r_num[2] !== 0) begin errors++; $display("FAIL err25_strobes: got %0d expected 0", r_num[0] + r_num[1] + r_num[2]); end
        checks++; if ({c50[0], c20[0], c10[0]} !== {6'd10, 6'd10, 6'd10}) begin errors++; $display("FAIL err25_counts: got %0d/%0d/%0d expected 10/10/10", c50[0], c20[0], c10[0]); end
    endtask

    task automatic test_zero();
        run_req(0, 0, 1'b0, 1'b0);
        checks++; if (r_done_cyc !== 2) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 2", r_done_cyc); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL zero_error: got %b expected 0", r_err); end
        checks++; if (r_num[0] + r_num[1] + r_num[2] !== 0) begin errors++; $display("FAIL zero_strobes: got %0d expected 0", r_num[0] + r_num[1] + r_num[2]); end
        checks++; if (r_ready_cyc !== 3) begin errors++; $display("FAIL zero_ready_cycle: got %0d expected 3", r_ready_cyc); end
    endtask

    task automatic test_pay_80();
        run_req(0, 80, 1'b0, 1'b0);
        checks++; if (r_first[0] !== 2) begin errors++; $display("FAIL pay80_fifty_cycle: got %0d expected 2", r_first[0]); end
        checks++; if (r_first[1] !== 4) begin errors++; $display("FAIL pay80_twenty_cycle: got %0d expected 4", r_first[1]); end
        checks++; if (r_first[2] !== 6) begin errors++; $display("FAIL pay80_ten_cycle: got %0d expected 6", r_first[2]); end
        checks++; if ({r_num[0], r_num[1], r_num[2]} !== {32'd1, 32'd1, 32'd1}) begin errors++; $display("FAIL pay80_coin_num: got %0d/%0d/%0d expected 1/1/1", r_num[0], r_num[1], r_num[2]); end
        checks++; if (r_done_cyc !== 7 || r_err !== 1'b0) begin errors++; $display("FAIL pay80_done: got cycle %0d err %b expected cycle 7 err 0", r_done_cyc, r_err); end
        checks++; if (r_ready_cyc !== 8) begin errors++; $display("FAIL pay80_ready_cycle: got %0d expected 8", r_ready_cyc); end
        checks++; if (r_multi !== 0) begin errors++; $display("FAIL pay80_one_hot: got %0d multi-strobe cycles expected 0", r_multi); end
        checks++; if ({c50[0], c20[0], c10[0]} !== {6'd9, 6'd9, 6'd9}) begin errors++; $display("FAIL pay80_counts: got %0d/%0d/%0d expected 9/9/9", c50[0], c20[0], c10[0]); end
    endtask

    task automatic test_greedy();
        run_req(1, 60, 1'b0, 1'b0);
        checks++; if (r_num[1] !== 3 || r_num[0] + r_num[2] !== 0) begin errors++; $display("FAIL greedy60_coins: got %0d/%0d/%0d expected 0/3/0", r_num[0], r_num[1], r_num[2]); end
        checks++; if (r_done_cyc !== 7 || r_err !== 1'b0) begin errors++; $display("FAIL greedy60_done: got cycle %0d err %b expected cycle 7 err 0", r_done_cyc, r_err); end
        checks++; if ({c50[1], c20[1], c10[1]} !== 18'd0) begin errors++; $display("FAIL greedy60_counts: got %0d/%0d/%0d expected 0/0/0", c50[1], c20[1], c10[1]); end
        run_req(2, 60, 1'b0, 1'b0);
        checks++; if (r_done_cyc !== 2 || r_err !== 1'b1) begin errors++; $display("FAIL greedy60_fail_done: got cycle %0d err %b expected cycle 2 err 1", r_done_cyc, r_err); end
        checks++; if (r_num[0] + r_num[1] + r_num[2] !== 0) begin errors++; $display("FAIL greedy60_fail_strobes: got %0d expected 0", r_num[0] + r_num[1] + r_num[2]); end
        checks++; if ({c50[2], c20[2], c10[2]} !== {6'd1, 6'd3, 6'd0}) begin errors++; $display("FAIL greedy60_fail_counts: got %0d/%0d/%0d expected 1/3/0", c50[2], c20[2], c10[2]); end
    endtask

    task automatic test_back_to_back();
        run_req(3, 10, 1'b0, 1'b0);
        checks++; if (r_first[2] !== 2 || r_num[2] !== 1) begin errors++; $display("FAIL b2b_first_ten: got cycle %0d num %0d expected cycle 2 num 1", r_first[2], r_num[2]); end
        checks++; if (r_done_cyc !== 3 || r_err !== 1'b0) begin errors++; $display("FAIL b2b_first_done: got cycle %0d err %b expected cycle 3 err 0", r_done_cyc, r_err); end
        run_req(3, 10, 1'b0, 1'b0);
        checks++; if (r_done_cyc !== 2 || r_err !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got cycle %0d err %b expected cycle 2 err 1", r_done_cyc, r_err); end
        checks++; if (c10[3] !== 6'd0) begin errors++; $display("FAIL b2b_second_ten_cnt: got %0d expected 0", c10[3]); end
        run_req(3, 10, 1'b1, 1'b0);
        checks++; if (r_done_cyc !== 3 || r_err !== 1'b0 || r_num[2] !== 1) begin errors++; $display("FAIL refill_req: got cycle %0d err %b tens %0d expected cycle 3 err 0 tens 1", r_done_cyc, r_err, r_num[2]); end
        checks++; if ({c50[3], c20[3], c10[3]} !== {6'd10, 6'd10, 6'd0}) begin errors++; $display("FAIL refill_req_counts: got %0d/%0d/%0d expected 10/10/0", c50[3], c20[3], c10[3]); end
    endtask

    task automatic test_refill_ignored();
        run_req(0, 80, 1'b0, 1'b1);
        checks++; if (r_done_cyc !== 7 || r_err !== 1'b0) begin errors++; $display("FAIL refill_busy_done: got cycle %0d err %b expected cycle 7 err 0", r_done_cyc, r_err); end
        checks++; if ({c50[0], c20[0], c10[0]} !== {6'd8, 6'd8, 6'd8}) begin errors++; $display("FAIL refill_busy_counts: got %0d/%0d/%0d expected 8/8/8", c50[0], c20[0], c10[0]); end
    endtask

    task automatic test_reset_midpay();
        int   waited;
        logic saw_done;
        @(negedge i_clk);
        req_valid[0]  = 1'b1;
        req_amount[0] = 8'd80;
        @(posedge i_clk);
        #1;
        req_valid[0] = 1'b0;
        waited = 0;
        while (!fifty[0] && waited < 10) begin
            @(posedge i_clk);
            #1;
            waited++;
        end
        checks++; if (fifty[0] !== 1'b1) begin errors++; $display("FAIL rst_first_strobe: got %b expected 1", fifty[0]); end
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        checks++; if (twenty[0] !== 1'b1) begin errors++; $display("FAIL rst_second_strobe: got %b expected 1", twenty[0]); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if ({fifty[0], twenty[0], ten[0]} !== 3'b000) begin errors++; $display("FAIL rst_strobes_low: got %b expected 000", {fifty[0], twenty[0], ten[0]}); end
        checks++; if (ready[0] !== 1'b1 || done[0] !== 1'b0) begin errors++; $display("FAIL rst_ready_done: got ready %b done %b expected ready 1 done 0", ready[0], done[0]); end
        checks++; if ({c50[0], c20[0], c10[0]} !== {6'd10, 6'd10, 6'd10}) begin errors++; $display("FAIL rst_counts: got %0d/%0d/%0d expected 10/10/10", c50[0], c20[0], c10[0]); end
        saw_done = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge i_clk);
            #1;
            saw_done |= done[0];
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_no_done: got %b expected 0", saw_done); end
        checks++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b expected 1", ready[0]); end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            req_valid[k]  = 1'b0;
            req_amount[k] = 8'd0;
            refill[k]     = 1'b0;
        end
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        test_reset();
        test_unpayable();
        test_zero();
        test_pay_80();
        test_greedy();
        test_back_to_back();
        test_refill_ignored();
        test_reset_midpay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
